cdb_arbiter: RTL and testbench

Schedules the core's single common data bus (CDB) among the execution units (ALU, MUL, DIV, LSU). Each unit owns a one-entry holding buffer. Every cycle the arbiter picks the buffered result whose ROB tag is oldest relative to the ROB head and drives it onto a registered CDB. The ROB, reservation stations and register-status logic consume that broadcast. A flush from the ROB squashes all pending results.

---
 rtl/cdb_pkg.sv | 28 ++
 rtl/age_select.sv | 41 ++++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants and types for the common data bus.
//   NUM_FU     number of execution units competing for the CDB
//   ROB_IDX_W  ROB tag width (ROB depth is 2**ROB_IDX_W)
//   DATA_W     result width
//   fu_id_e    execution unit index (ALU, MUL, DIV, LSU)
//   cdb_t      one CDB broadcast, consumed by the ROB and reservation stations
package cdb_pkg;

    localparam int unsigned NUM_FU    = 4;
    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned SRC_W     = $clog2(NUM_FU);

    typedef enum logic [SRC_W-1:0] {
        FU_ALU,
        FU_MUL,
        FU_DIV,
        FU_LSU
    } fu_id_e;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] tag;
        logic [DATA_W-1:0]    data;
        logic [SRC_W-1:0]     src;
    } cdb_t;

endpackage

// File: rtl/age_select.sv
// age_select: combinational oldest-first selector for the CDB.
//   i_buf_v     per-unit holding buffer valid
//   i_buf_tag   per-unit buffered ROB tag, unit i at [i*ROB_IDX_W +: ROB_IDX_W]
//   i_rob_head  tag of the oldest in-flight ROB entry
//   o_grant     one-hot (or zero) grant to the buffer with the smallest age
module age_select
    import cdb_pkg::*;
(
    input  logic [NUM_FU-1:0]           i_buf_v,
    input  logic [NUM_FU*ROB_IDX_W-1:0] i_buf_tag,
    input  logic [ROB_IDX_W-1:0]        i_rob_head,
    output logic [NUM_FU-1:0]           o_grant
);

    logic                 w_best_v;
    logic [ROB_IDX_W-1:0] w_best_age;
    logic [SRC_W-1:0]     w_best_idx;
    logic [ROB_IDX_W-1:0] w_age;

    always_comb begin
        w_best_v   = 1'b0;
        w_best_age = '0;
        w_best_idx = '0;
        w_age      = '0;
        o_grant    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            // Modular distance from the head; wraps naturally at ROB_IDX_W bits.
            w_age = i_buf_tag[i*ROB_IDX_W +: ROB_IDX_W] - i_rob_head;
            // Strict compare keeps the lower index on an (illegal) tie.
            if (i_buf_v[i] && (!w_best_v || (w_age < w_best_age))) begin
                w_best_v   = 1'b1;
                w_best_age = w_age;
                w_best_idx = SRC_W'(i);
            end
        end
        if (w_best_v) begin
            o_grant[w_best_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: schedules the single common data bus among the execution units.
//   i_clk, i_rst_n   core clock, asynchronous active-low reset
//   i_fu_valid       unit i presents a result
//   i_fu_tag         unit i ROB tag at [i*ROB_IDX_W +: ROB_IDX_W]
//   i_fu_data        unit i result at [i*DATA_W +: DATA_W]
//   o_fu_ready       unit i holding buffer can accept this cycle
//   i_rob_head       oldest in-flight ROB tag, used for age ordering
//   i_flush          squash all buffered results and the pending broadcast
//   o_cdb_valid/tag/data/src   registered broadcast
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_FU-1:0]           i_fu_valid,
    input  logic [NUM_FU*ROB_IDX_W-1:0] i_fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]    i_fu_data,
    output logic [NUM_FU-1:0]           o_fu_ready,
    input  logic [ROB_IDX_W-1:0]        i_rob_head,
    input  logic                        i_flush,
    output logic                        o_cdb_valid,
    output logic [ROB_IDX_W-1:0]        o_cdb_tag,
    output logic [DATA_W-1:0]           o_cdb_data,
    output logic [SRC_W-1:0]            o_cdb_src
);

    logic [NUM_FU-1:0]           r_buf_v;
    logic [NUM_FU*ROB_IDX_W-1:0] r_buf_tag;
    logic [NUM_FU*DATA_W-1:0]    r_buf_data;
    cdb_t                        r_cdb;

    logic [NUM_FU-1:0]    w_grant;
    logic [NUM_FU-1:0]    w_ready;
    logic [NUM_FU-1:0]    w_load;
    logic [ROB_IDX_W-1:0] w_win_tag;
    logic [DATA_W-1:0]    w_win_data;
    logic [SRC_W-1:0]     w_win_src;

    // Arbitration sees only the buffers, never the live inputs.
    age_select u_age_select (
        .i_buf_v    (r_buf_v),
        .i_buf_tag  (r_buf_tag),
        .i_rob_head (i_rob_head),
        .o_grant    (w_grant)
    );

    // A buffer being granted this cycle empties at the edge, so it can reload.
    assign w_ready = {NUM_FU{~i_flush}} & (~r_buf_v | w_grant);
    assign w_load  = i_fu_valid & w_ready;

    always_comb begin
        w_win_tag  = '0;
        w_win_data = '0;
        w_win_src  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_grant[i]) begin
                w_win_tag  = r_buf_tag[i*ROB_IDX_W +: ROB_IDX_W];
                w_win_data = r_buf_data[i*DATA_W +: DATA_W];
                w_win_src  = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_v    <= '0;
            r_buf_tag  <= '0;
            r_buf_data <= '0;
            r_cdb      <= '0;
        end else if (i_flush) begin
            // Payload registers keep stale values; only the valids matter.
            r_buf_v     <= '0;
            r_cdb.valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_load[i]) begin
                    r_buf_v[i]                              <= 1'b1;
                    r_buf_tag[i*ROB_IDX_W +: ROB_IDX_W]     <= i_fu_tag[i*ROB_IDX_W +: ROB_IDX_W];
                    r_buf_data[i*DATA_W +: DATA_W]          <= i_fu_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_buf_v[i] <= 1'b0;
                end
            end
            r_cdb.valid <= |w_grant;
            // Payload holds its last value when nothing wins.
            if (|w_grant) begin
                r_cdb.tag  <= w_win_tag;
                r_cdb.data <= w_win_data;
                r_cdb.src  <= w_win_src;
            end
        end
    end

    assign o_fu_ready  = w_ready;
    assign o_cdb_valid = r_cdb.valid;
    assign o_cdb_tag   = r_cdb.tag;
    assign o_cdb_data  = r_cdb.data;
    assign o_cdb_src   = r_cdb.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   fu_valid = '0;
    logic [19:0]  fu_tag = '0;
    logic [127:0] fu_data = '0;
    logic [3:0]   fu_ready;
    logic [4:0]   rob_head = '0;
    logic         flush = 1'b0;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;

    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b1;
    cdb_t exp_q[$];

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_fu_valid  (fu_valid),
        .i_fu_tag    (fu_tag),
        .i_fu_data   (fu_data),
        .o_fu_ready  (fu_ready),
        .i_rob_head  (rob_head),
        .i_flush     (flush),
        .o_cdb_valid (cdb_valid),
        .o_cdb_tag   (cdb_tag),
        .o_cdb_data  (cdb_data),
        .o_cdb_src   (cdb_src)
    );

    // Scoreboard: every broadcast must match the head of the expected queue.
    always @(negedge clk) begin
        cdb_t got;
        cdb_t exp;
        if (mon_en && rst_n && cdb_valid) begin
            got.valid = cdb_valid;
            got.tag   = cdb_tag;
            got.data  = cdb_data;
            got.src   = cdb_src;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected: got tag=%0d data=%h src=%0d, required no broadcast",
                         cdb_tag, cdb_data, cdb_src);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL cdb_order: got tag=%0d data=%h src=%0d, required tag=%0d data=%h src=%0d",
                             got.tag, got.data, got.src, exp.tag, exp.data, exp.src);
                end
            end
        end
    end

    // Protocol watch: stalled inputs must stay stable; simultaneous tags must be unique.
    logic [3:0]   p_stall = '0;
    logic [19:0]  p_tag = '0;
    logic [127:0] p_data = '0;
    logic         p_flush = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 4; u++) begin
                if (p_stall[u] && !p_flush &&
                    (!fu_valid[u] || fu_tag[u*5 +: 5] !== p_tag[u*5 +: 5] ||
                     fu_data[u*32 +: 32] !== p_data[u*32 +: 32])) begin
                    errors++;
                    $display("FAIL protocol_hold: unit %0d got valid=%0b tag=%0d, required held tag=%0d",
                             u, fu_valid[u], fu_tag[u*5 +: 5], p_tag[u*5 +: 5]);
                end
                for (int v = u + 1; v < 4; v++) begin
                    if (fu_valid[u] && fu_valid[v] && fu_tag[u*5 +: 5] == fu_tag[v*5 +: 5]) begin
                        errors++;
                        $display("FAIL tag_tie: units %0d and %0d both got tag=%0d, required distinct",
                                 u, v, fu_tag[u*5 +: 5]);
                    end
                end
            end
        end
        p_stall <= rst_n ? (fu_valid & ~fu_ready) : 4'b0;
        p_tag   <= fu_tag;
        p_data  <= fu_data;
        p_flush <= flush;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int u, input logic [4:0] t, input logic [31:0] d);
        fu_valid[u]        = 1'b1;
        fu_tag[u*5 +: 5]   = t;
        fu_data[u*32 +: 32] = d;
    endtask

    task automatic push_exp(input logic [4:0] t, input logic [31:0] d, input logic [1:0] s);
        cdb_t e;
        e.valid = 1'b1;
        e.tag   = t;
        e.data  = d;
        e.src   = s;
        exp_q.push_back(e);
    endtask

    task automatic drain_and_check(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d broadcasts outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== 40'd0) begin
            errors++;
            $display("FAIL reset_cdb: got valid=%0b tag=%0d data=%h src=%0d, required all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (fu_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1111", fu_ready);
        end
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b, required 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        logic [31:0] d = 32'd42;
        rob_head = 5'd0;
        step();
        set_fu(0, 5'd3, d);
        push_exp(5'd3, d, 2'd0);
        @(negedge clk);
        checks++;
        if (fu_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %0b, required 1", fu_ready[0]);
        end
        step();
        fu_valid = '0;
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got valid=%0b one cycle after input, required 0", cdb_valid);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got valid=%0b two cycles after input, required 1", cdb_valid);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_once: got valid=%0b on third cycle, required 0", cdb_valid);
        end
        drain_and_check("single");
    endtask

    task automatic test_wrap();
        logic [31:0] d1 = $urandom();
        logic [31:0] d2 = $urandom();
        logic [31:0] d3 = $urandom();
        rob_head = 5'd30;
        step();
        set_fu(1, 5'd1, d1);
        set_fu(2, 5'd31, d2);
        set_fu(3, 5'd0, d3);
        push_exp(5'd31, d2, 2'd2);
        push_exp(5'd0, d3, 2'd3);
        push_exp(5'd1, d1, 2'd1);
        step();
        fu_valid = '0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cdb_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_consecutive: got valid=%0b in slot %0d, required 1", cdb_valid, k);
            end
        end
        drain_and_check("wrap");
    endtask

    task automatic test_stream();
        rob_head = 5'd0;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] d = $urandom();
            step();
            set_fu(0, 5'(k + 8), d);
            push_exp(5'(k + 8), d, 2'd0);
            @(negedge clk);
            checks++;
            if (fu_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: got %0b at beat %0d, required 1", fu_ready[0], k);
            end
            if (k >= 2) begin
                checks++;
                if (cdb_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_valid: got %0b at beat %0d, required 1", cdb_valid, k);
                end
            end
        end
        step();
        fu_valid = '0;
        drain_and_check("stream");
    endtask

    task automatic test_contention();
        logic [31:0] d_div = $urandom();
        logic [31:0] d_a6  = $urandom();
        logic [31:0] d_a7  = $urandom();
        rob_head = 5'd0;
        step();
        set_fu(2, 5'd2, d_div);
        set_fu(0, 5'd6, d_a6);
        push_exp(5'd2, d_div, 2'd2);
        push_exp(5'd6, d_a6, 2'd0);
        push_exp(5'd7, d_a7, 2'd0);
        step();
        fu_valid[2] = 1'b0;
        set_fu(0, 5'd7, d_a7);
        @(negedge clk);
        checks++;
        if (fu_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL contention_stall: got ready=%0b, required 0", fu_ready[0]);
        end
        step();
        @(negedge clk);
        checks++;
        if (fu_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL contention_release: got ready=%0b, required 1", fu_ready[0]);
        end
        step();
        fu_valid = '0;
        drain_and_check("contention");
    endtask

    task automatic test_flush();
        int seen = 0;
        logic [31:0] d = $urandom();
        rob_head = 5'd0;
        step();
        for (int u = 0; u < 4; u++) set_fu(u, 5'(u + 4), $urandom());
        step();
        fu_valid = '0;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (fu_ready !== 4'h0) begin
            errors++;
            $display("FAIL flush_ready_low: got %b, required 0000", fu_ready);
        end
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (fu_ready !== 4'hF) begin
            errors++;
            $display("FAIL flush_ready_back: got %b, required 1111", fu_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (cdb_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_squash: got %0d broadcasts after flush, required 0", seen);
        end
        step();
        set_fu(0, 5'd9, d);
        push_exp(5'd9, d, 2'd0);
        step();
        fu_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_recover: got valid=%0b, required 1", cdb_valid);
        end
        drain_and_check("flush");
    endtask

    task automatic test_async_reset();
        int seen = 0;
        rob_head = 5'd0;
        mon_en = 1'b0;
        step();
        for (int u = 0; u < 4; u++) set_fu(u, 5'(u + 10), $urandom());
        step();
        fu_valid = '0;
        @(negedge clk);
        checks++;
        if (fu_ready !== 4'b0001) begin
            errors++;
            $display("FAIL areset_full: got ready=%b, required 0001", fu_ready);
        end
        step();
        #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 5'd10) begin
            errors++;
            $display("FAIL areset_pre: got valid=%0b tag=%0d, required valid=1 tag=10",
                     cdb_valid, cdb_tag);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== 40'd0) begin
            errors++;
            $display("FAIL areset_cdb: got valid=%0b tag=%0d data=%h src=%0d, required all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
        checks++;
        if (fu_ready !== 4'hF) begin
            errors++;
            $display("FAIL areset_ready: got %b, required 1111", fu_ready);
        end
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cdb_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL areset_buffers: got %0d broadcasts after reset, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_stream();
        test_contention();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
